// File: rtl/dds_config_tx.sv
// Serial configuration transmitter for the excitation DDS: optional reset pulse,
// 40 data bits LSB first under a word clock, then a frequency-update strobe.
module dds_config_tx #(
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 8
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        start,
  input  logic        load_rst,
  input  logic [39:0] word,
  output logic        dds_rst,
  output logic        dds_wclk,
  output logic        dds_data,
  output logic        dds_conf,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_GAP,
    S_BIT_LO,
    S_BIT_HI,
    S_UPD
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [5:0]  BIT_LAST = 6'd39;

  state_t      state, state_nxt;
  logic [15:0] phase, phase_nxt;
  logic [5:0]  bit_cnt, bit_cnt_nxt;
  logic [39:0] sreg, sreg_nxt;
  logic        rst_nxt, wclk_nxt, data_nxt, conf_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      sreg     <= '0;
      dds_rst  <= 1'b0;
      dds_wclk <= 1'b0;
      dds_data <= 1'b0;
      dds_conf <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      bit_cnt  <= bit_cnt_nxt;
      sreg     <= sreg_nxt;
      dds_rst  <= rst_nxt;
      dds_wclk <= wclk_nxt;
      dds_data <= data_nxt;
      dds_conf <= conf_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Every state lasts a whole number of phase counts; phase restarts at 0 on each transition.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase + 16'd1;
    bit_cnt_nxt = bit_cnt;
    sreg_nxt    = sreg;
    done_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        phase_nxt = '0;
        if (start) begin
          sreg_nxt    = word;
          bit_cnt_nxt = '0;
          state_nxt   = load_rst ? S_RST : S_BIT_LO;
        end
      end
      S_RST: begin
        if (phase == RST_LAST) begin
          phase_nxt = '0;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (phase == DIV_LAST) begin
          phase_nxt = '0;
          state_nxt = S_BIT_LO;
        end
      end
      S_BIT_LO: begin
        if (phase == DIV_LAST) begin
          phase_nxt = '0;
          state_nxt = S_BIT_HI;
        end
      end
      S_BIT_HI: begin
        if (phase == DIV_LAST) begin
          phase_nxt = '0;
          sreg_nxt  = {1'b0, sreg[39:1]};
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = S_UPD;
          end else begin
            bit_cnt_nxt = bit_cnt + 6'd1;
            state_nxt   = S_BIT_LO;
          end
        end
      end
      S_UPD: begin
        if (phase == DIV_LAST) begin
          phase_nxt = '0;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        phase_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Pins are decoded from the next state so they are registered yet aligned with it;
  // data is refreshed only on entry to BIT_LO and held through BIT_HI.
  always_comb begin
    rst_nxt  = (state_nxt == S_RST);
    wclk_nxt = (state_nxt == S_BIT_HI);
    conf_nxt = (state_nxt == S_UPD);
    busy_nxt = (state_nxt != S_IDLE);
    data_nxt = 1'b0;
    case (state_nxt)
      S_BIT_LO: data_nxt = sreg_nxt[0];
      S_BIT_HI: data_nxt = dds_data;
      default:  data_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dds_config_tx.sv
// Randomized self-checking bench for dds_config_tx: one instance at the default
// timing, one at the fastest timing for back-to-back sequences.
module tb_dds_config_tx;

  localparam int CD0 = 4;
  localparam int RC0 = 8;
  localparam int CD1 = 1;
  localparam int RC1 = 1;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [1:0]  start, load_rst;
  logic [39:0] word_a [2];
  logic [1:0]  dds_rst, dds_wclk, dds_data, dds_conf, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // Observation counters, only ever incremented by the monitor.
  int          cyc = 0;
  int          busy_c [2] = '{0, 0};
  int          rst_c  [2] = '{0, 0};
  int          conf_c [2] = '{0, 0};
  int          done_c [2] = '{0, 0};
  int          rise_c [2] = '{0, 0};
  int          viol_c [2] = '{0, 0};
  int          seq_r  [2] = '{0, 0};
  int          last_r [2] = '{0, 0};
  logic [39:0] cap    [2];
  logic [1:0]  pwclk = '0;
  logic [1:0]  pdata = '0;

  always #5 clk_sys = ~clk_sys;

  dds_config_tx #(.CLK_DIV(CD0), .RST_CYCLES(RC0)) u_dut0 (
    .clk_sys (clk_sys),     .rst_n   (rst_n),
    .start   (start[0]),    .load_rst(load_rst[0]), .word(word_a[0]),
    .dds_rst (dds_rst[0]),  .dds_wclk(dds_wclk[0]), .dds_data(dds_data[0]),
    .dds_conf(dds_conf[0]), .busy    (busy[0]),     .done(done[0])
  );

  dds_config_tx #(.CLK_DIV(CD1), .RST_CYCLES(RC1)) u_dut1 (
    .clk_sys (clk_sys),     .rst_n   (rst_n),
    .start   (start[1]),    .load_rst(load_rst[1]), .word(word_a[1]),
    .dds_rst (dds_rst[1]),  .dds_wclk(dds_wclk[1]), .dds_data(dds_data[1]),
    .dds_conf(dds_conf[1]), .busy    (busy[1]),     .done(done[1])
  );

  function automatic int cd(input int i);
    return (i == 0) ? CD0 : CD1;
  endfunction

  function automatic int rc(input int i);
    return (i == 0) ? RC0 : RC1;
  endfunction

  // Reference: reset phase + gap if requested, then 40 bits of two half-periods and the update strobe.
  function automatic int exp_busy(input int i, input logic lr);
    return (lr ? (rc(i) + cd(i)) : 0) + 80 * cd(i) + cd(i);
  endfunction

  function automatic logic [39:0] rand40();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[39:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always begin
    @(posedge clk_sys);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (busy[i])     busy_c[i]++;
      if (dds_rst[i])  rst_c[i]++;
      if (dds_conf[i]) conf_c[i]++;
      if (done[i])     done_c[i]++;
      if (int'(dds_rst[i]) + int'(dds_wclk[i]) + int'(dds_conf[i]) > 1) viol_c[i]++;
      if (dds_wclk[i] && (dds_data[i] != pdata[i])) viol_c[i]++;
      if (!busy[i]) seq_r[i] = 0;
      if (dds_wclk[i] && !pwclk[i]) begin
        if (seq_r[i] > 0 && (cyc - last_r[i]) != 2 * cd(i)) viol_c[i]++;
        last_r[i] = cyc;
        seq_r[i]++;
        rise_c[i]++;
        cap[i] = {dds_data[i], cap[i][39:1]};
      end
      pwclk[i] = dds_wclk[i];
      pdata[i] = dds_data[i];
    end
  end

  // Starts a sequence from a negedge and returns at the negedge of its done cycle,
  // so a following call asserts start in the done cycle.
  task automatic run_seq(input int i, input logic [39:0] w, input logic lr, input int ign);
    int  n;
    bit  seen;
    int  b_busy, b_rst, b_conf, b_done, b_rise, b_viol;
    b_busy = busy_c[i]; b_rst = rst_c[i]; b_conf = conf_c[i];
    b_done = done_c[i]; b_rise = rise_c[i]; b_viol = viol_c[i];
    word_a[i]   = w;
    load_rst[i] = lr;
    start[i]    = 1'b1;
    @(negedge clk_sys);
    start[i]    = 1'b0;
    word_a[i]   = rand40();
    load_rst[i] = 1'($urandom_range(0, 1));
    check($sformatf("busy_rise%0d", i), 64'(busy[i]), 64'd1);
    n = 1;
    seen = 0;
    while (!seen && n < 3000) begin
      if (n == ign) begin
        start[i]    = 1'b1;
        word_a[i]   = '1;
        load_rst[i] = 1'b1;
      end else begin
        start[i] = 1'b0;
      end
      @(negedge clk_sys);
      n++;
      if (done[i]) seen = 1;
    end
    start[i] = 1'b0;
    check($sformatf("done_seen%0d", i), 64'(seen), 64'd1);
    check($sformatf("busy_len%0d", i), 64'(busy_c[i] - b_busy), 64'(exp_busy(i, lr)));
    check($sformatf("rst_len%0d", i), 64'(rst_c[i] - b_rst), 64'(lr ? rc(i) : 0));
    check($sformatf("conf_len%0d", i), 64'(conf_c[i] - b_conf), 64'(cd(i)));
    check($sformatf("wclk_rises%0d", i), 64'(rise_c[i] - b_rise), 64'd40);
    check($sformatf("bits%0d", i), 64'(cap[i]), 64'(w));
    check($sformatf("done_cnt%0d", i), 64'(done_c[i] - b_done), 64'd1);
    check($sformatf("busy_at_done%0d", i), 64'(busy[i]), 64'd0);
    check($sformatf("pin_rules%0d", i), 64'(viol_c[i] - b_viol), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk_sys);
  endtask

  initial begin
    int          b_rise, b_conf, b_done, n;
    logic [39:0] w;
    rst_n     = 1'b0;
    start     = 2'b11;
    load_rst  = 2'b11;
    word_a[0] = rand40();
    word_a[1] = rand40();
    cap[0]    = '0;
    cap[1]    = '0;

    // Reset held with start asserted: nothing may move.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      check("reset_outs", 64'({dds_rst, dds_wclk, dds_data, dds_conf, busy, done}), 64'd0);
    end
    rst_n = 1'b1;
    start = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      check("idle_busy", 64'(busy), 64'd0);
    end

    run_seq(0, 40'hA5_1234_5678, 1'b1, -1);
    idle(3);
    run_seq(0, 40'h00_0000_0001, 1'b0, -1);
    idle(2);
    run_seq(0, 40'h0, 1'b1, 50);
    idle(2);

    // Mid-sequence reset during bit 20.
    b_rise = rise_c[0];
    word_a[0]   = rand40();
    load_rst[0] = 1'b0;
    start[0]    = 1'b1;
    @(negedge clk_sys);
    start[0] = 1'b0;
    n = 0;
    while ((rise_c[0] - b_rise) < 21 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check("reach_bit20", 64'(rise_c[0] - b_rise), 64'd21);
    b_conf = conf_c[0];
    b_done = done_c[0];
    rst_n = 1'b0;
    @(negedge clk_sys);
    check("midrst_outs", 64'({dds_rst[0], dds_wclk[0], dds_data[0], dds_conf[0], busy[0], done[0]}), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(400);
    check("midrst_no_conf", 64'(conf_c[0] - b_conf), 64'd0);
    check("midrst_no_done", 64'(done_c[0] - b_done), 64'd0);
    check("midrst_idle", 64'(busy[0]), 64'd0);
    run_seq(0, rand40(), 1'b1, -1);
    idle(2);

    for (int k = 0; k < 3; k++) begin
      w = rand40();
      run_seq(0, w, 1'($urandom_range(0, 1)), -1);
      idle(int'($urandom_range(0, 3)));
    end

    // Fastest timing, chained with start in each done cycle.
    run_seq(1, rand40(), 1'b1, -1);
    run_seq(1, rand40(), 1'b1, -1);
    for (int k = 0; k < 3; k++) begin
      run_seq(1, rand40(), 1'($urandom_range(0, 1)), -1);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
